// File: rtl/dlfloat_result_serializer.sv
// DLFloat result serializer: buffers 16-bit MAC results and streams them as low-then-high byte frames.
// Optional macro DLFLOAT_SER_FLAGS_EN appends a status byte {5'b0, is_zero, sign, is_nan} to every frame.

module dlfloat_ser_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdat,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdat,
  output logic [PTR_W:0]   o_count
);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdat  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

module dlfloat_result_serializer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             res_valid,
  input  logic [15:0]      res_data,
  output logic             res_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [PTR_W:0]   fifo_count,
  output logic [7:0]       drop_cnt
);

`ifdef DLFLOAT_SER_FLAGS_EN
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_FLG} state_t;
  localparam logic LP_HI_LAST = 1'b0;
`else
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;
  localparam logic LP_HI_LAST = 1'b1;
`endif

  localparam logic [PTR_W:0] LP_FULL = DEPTH[PTR_W:0];

  state_t         r_state;
  logic [15:0]    r_hold;
  logic [7:0]     r_out_data;
  logic           r_out_valid;
  logic           r_out_last;
  logic [7:0]     r_drop_cnt;

  logic [15:0]    w_head;
  logic [PTR_W:0] w_count;
  logic           w_res_ready;
  logic           w_push;
  logic           w_drop;
  logic           w_pop;
  logic           w_nonempty;
  logic           w_frame_end;

  // No bypass: a pop in the same cycle never frees a slot for the incoming word.
  assign w_res_ready = (w_count != LP_FULL);
  assign w_push      = res_valid && w_res_ready;
  assign w_drop      = res_valid && !w_res_ready;
  assign w_nonempty  = (w_count != '0);

`ifdef DLFLOAT_SER_FLAGS_EN
  logic w_is_nan;
  logic w_is_zero;
  logic w_sign;
  assign w_is_nan    = (r_hold == 16'hFFFF);
  assign w_is_zero   = (r_hold == 16'h0000);
  assign w_sign      = r_hold[15] && !w_is_nan;
  assign w_frame_end = (r_state == S_FLG) && out_ready;
`else
  assign w_frame_end = (r_state == S_HI) && out_ready;
`endif

  // Pop on the head-load from IDLE and on the last byte of a frame for back-to-back streaming.
  assign w_pop = w_nonempty && ((r_state == S_IDLE) || w_frame_end);

  dlfloat_ser_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_wdat  (res_data),
    .i_pop   (w_pop),
    .o_rdat  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;

      if (w_frame_end) begin
        if (w_nonempty) begin
          r_hold      <= w_head;
          r_out_data  <= w_head[7:0];
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_state     <= S_LO;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_state     <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_nonempty) begin
              r_hold      <= w_head;
              r_out_data  <= w_head[7:0];
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
              r_state     <= S_LO;
            end
          end
          S_LO: begin
            if (out_ready) begin
              r_out_data <= r_hold[15:8];
              r_out_last <= LP_HI_LAST;
              r_state    <= S_HI;
            end
          end
`ifdef DLFLOAT_SER_FLAGS_EN
          S_HI: begin
            if (out_ready) begin
              r_out_data <= {5'b0, w_is_zero, w_sign, w_is_nan};
              r_out_last <= 1'b1;
              r_state    <= S_FLG;
            end
          end
          S_FLG: r_state <= S_FLG;
`else
          S_HI: r_state <= S_HI;
`endif
          default: begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign res_ready  = w_res_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign fifo_count = w_count;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// Directed bench for dlfloat_result_serializer; inputs driven and outputs sampled 1ns after each rising edge.
// Flag-frame scenarios run when DLFLOAT_SER_FLAGS_EN is defined, plain 2-byte scenarios otherwise.

module tb_dlfloat_result_serializer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  dlfloat_result_serializer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_chk(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_data"}, {8'd0, out_data}, {8'd0, d});
    chk({tag, "_last"}, {15'd0, out_last}, {15'd0, l});
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_data", {8'd0, out_data}, 16'd0);
    chk("rst_last", {15'd0, out_last}, 16'd0);
    chk("rst_count", {13'd0, fifo_count}, 16'd0);
    chk("rst_drop", {8'd0, drop_cnt}, 16'd0);
    chk("rst_ready", {15'd0, res_ready}, 16'd1);
    step();
    rst = 1'b0;
    step();

`ifndef DLFLOAT_SER_FLAGS_EN
    // Single word 3E80
    out_ready = 1'b1;
    res_valid = 1'b1; res_data = 16'h3E80;
    step();
    res_valid = 1'b0;
    chk("single_latency_valid", {15'd0, out_valid}, 16'd0);
    chk("single_count", {13'd0, fifo_count}, 16'd1);
    step();
    byte_chk("single_lo", 8'h80, 1'b0);
    step();
    byte_chk("single_hi", 8'h3E, 1'b1);
    step();
    chk("single_idle", {15'd0, out_valid}, 16'd0);

    // Backpressure A5C3
    out_ready = 1'b0;
    res_valid = 1'b1; res_data = 16'hA5C3;
    step();
    res_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      byte_chk("bp_hold", 8'hC3, 1'b0);
      step();
    end
    byte_chk("bp_hold_end", 8'hC3, 1'b0);
    out_ready = 1'b1;
    step();
    byte_chk("bp_hi", 8'hA5, 1'b1);
    step();
    chk("bp_idle", {15'd0, out_valid}, 16'd0);

    // Overflow: six pushes with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      res_valid = 1'b1; res_data = 16'(i);
      step();
    end
    chk("ovf_count_full", {13'd0, fifo_count}, 16'd4);
    chk("ovf_ready_low", {15'd0, res_ready}, 16'd0);
    chk("ovf_drop_before", {8'd0, drop_cnt}, 16'd0);
    res_data = 16'h0006;
    step();
    res_valid = 1'b0;
    chk("ovf_drop_after", {8'd0, drop_cnt}, 16'd1);
    chk("ovf_count_after", {13'd0, fifo_count}, 16'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      byte_chk("ovf_drain_lo", 8'(i), 1'b0);
      step();
      byte_chk("ovf_drain_hi", 8'h00, 1'b1);
      step();
    end
    chk("ovf_drain_idle", {15'd0, out_valid}, 16'd0);
    chk("ovf_drain_count", {13'd0, fifo_count}, 16'd0);
    chk("ovf_drop_kept", {8'd0, drop_cnt}, 16'd1);

    // Back-to-back 1234, 5678
    res_valid = 1'b1; res_data = 16'h1234;
    step();
    res_data = 16'h5678;
    step();
    res_valid = 1'b0;
    byte_chk("b2b_0", 8'h34, 1'b0);
    step();
    byte_chk("b2b_1", 8'h12, 1'b1);
    step();
    byte_chk("b2b_2", 8'h78, 1'b0);
    step();
    byte_chk("b2b_3", 8'h56, 1'b1);
    step();
    chk("b2b_idle", {15'd0, out_valid}, 16'd0);

    // Flush while in HI with two words queued
    out_ready = 1'b0;
    res_valid = 1'b1; res_data = 16'h1111; step();
    res_data = 16'h2222; step();
    res_data = 16'h3333; step();
    res_valid = 1'b0;
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    byte_chk("flush_pre_hi", 8'h11, 1'b1);
    chk("flush_pre_count", {13'd0, fifo_count}, 16'd2);
    chk("flush_pre_drop", {8'd0, drop_cnt}, 16'd1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid", {15'd0, out_valid}, 16'd0);
    chk("flush_last", {15'd0, out_last}, 16'd0);
    chk("flush_count", {13'd0, fifo_count}, 16'd0);
    chk("flush_drop", {8'd0, drop_cnt}, 16'd0);
    step();
    chk("flush_stays_idle", {15'd0, out_valid}, 16'd0);

    // Async reset while in HI with two words queued
    res_valid = 1'b1; res_data = 16'h4444; step();
    res_data = 16'h5555; step();
    res_data = 16'h6666; step();
    res_valid = 1'b0;
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    byte_chk("arst_pre_hi", 8'h44, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {15'd0, out_valid}, 16'd0);
    chk("arst_last", {15'd0, out_last}, 16'd0);
    chk("arst_count", {13'd0, fifo_count}, 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("arst_no_partial", {15'd0, out_valid}, 16'd0);
`else
    // Status-byte frames
    out_ready = 1'b1;
    res_valid = 1'b1; res_data = 16'hFFFF; step();
    res_data = 16'h8000; step();
    res_valid = 1'b0;
    byte_chk("flg_nan_lo", 8'hFF, 1'b0); step();
    byte_chk("flg_nan_hi", 8'hFF, 1'b0); step();
    byte_chk("flg_nan_st", 8'h01, 1'b1); step();
    byte_chk("flg_neg_lo", 8'h00, 1'b0); step();
    byte_chk("flg_neg_hi", 8'h80, 1'b0); step();
    byte_chk("flg_neg_st", 8'h02, 1'b1); step();
    chk("flg_idle", {15'd0, out_valid}, 16'd0);
    res_valid = 1'b1; res_data = 16'h0000; step();
    res_valid = 1'b0;
    step();
    byte_chk("flg_zero_lo", 8'h00, 1'b0); step();
    byte_chk("flg_zero_hi", 8'h00, 1'b0); step();
    byte_chk("flg_zero_st", 8'h04, 1'b1); step();
    chk("flg_zero_idle", {15'd0, out_valid}, 16'd0);
    chk("flg_count", {13'd0, fifo_count}, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
